// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner of the 4:1 mux channel.
// Drives the mux select, waits a settle window after every select change,
// then issues a one-hot grant with out_valid for a bounded tenure.
//
// state  | meaning
// IDLE   | no requester pending; sel held, gnt = 0
// SETTLE | sel points at the winner; waiting for the mux output to propagate
// GRANT  | winner owns the channel; gnt one-hot, out_valid = 1
module mux4_rr_arbiter #(
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_HOLD      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       out_valid
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GRANT  = 2'd2
  } state_e;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] HOLD_LIMIT  = 8'(MAX_HOLD);

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] gnt_q, gnt_d;
  logic       out_valid_q, out_valid_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] settle_cnt_q, settle_cnt_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;

  // First requester after p in circular order (p+1, p+2, p+3, p).
  // Result is meaningless when r is all-zero; callers check that first.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = p;
    // Walk from farthest to nearest so the nearest hit is the final assignment.
    for (int k = 4; k >= 1; k--) begin
      idx = p + 2'(k);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  // Next-state and registered-output computation; everything holds by default.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    gnt_d        = gnt_q;
    out_valid_d  = out_valid_q;
    ptr_d        = ptr_q;
    settle_cnt_d = settle_cnt_q;
    hold_cnt_d   = hold_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (req != 4'b0000) begin
          sel_d        = rr_pick(req, ptr_q);
          settle_cnt_d = SETTLE_LOAD;
          state_d      = SETTLE;
        end
      end

      SETTLE: begin
        if (!req[sel_q]) begin
          // Requester withdrew before grant: pointer untouched, nobody served.
          state_d = IDLE;
        end else if (settle_cnt_q == 4'd0) begin
          state_d     = GRANT;
          gnt_d       = 4'b0001 << sel_q;
          out_valid_d = 1'b1;
          hold_cnt_d  = 8'd1;
        end else begin
          settle_cnt_d = settle_cnt_q - 4'd1;
        end
      end

      GRANT: begin
        if (!req[sel_q] || hold_cnt_q == HOLD_LIMIT) begin
          gnt_d       = 4'b0000;
          out_valid_d = 1'b0;
          ptr_d       = sel_q;
          // Re-arbitrate on the same edge with the holder as the new pointer,
          // so a waiting requester goes straight to SETTLE without an IDLE bubble.
          // A sole requester at its hold limit re-settles on the same select.
          if (req == 4'b0000) begin
            state_d = IDLE;
          end else begin
            sel_d        = rr_pick(req, sel_q);
            settle_cnt_d = SETTLE_LOAD;
            state_d      = SETTLE;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end

      default: begin
        state_d     = IDLE;
        gnt_d       = 4'b0000;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears the grant immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= 2'b00;
      gnt_q        <= 4'b0000;
      out_valid_q  <= 1'b0;
      ptr_q        <= 2'd3;
      settle_cnt_q <= 4'd0;
      hold_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      gnt_q        <= gnt_d;
      out_valid_q  <= out_valid_d;
      ptr_q        <= ptr_d;
      settle_cnt_q <= settle_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign sel       = sel_q;
  assign gnt       = gnt_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares the 4-input, 1-output gate-level mux channel between four requesters.
- Drives the mux select pair (s1 = sel[1], s0 = sel[0]) and issues a one-hot grant.
- Inserts a programmable settle window after each select change so the mux output has propagated before out_valid rises.
- Sits in front of the mux; requester i drives mux data input i.

Parameters:
SETTLE_CYCLES, 2, clock cycles between a select change and grant; legal range 1..15.
MAX_HOLD, 8, maximum consecutive granted cycles per tenure; legal range 1..255.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
req  input  4  request vector; req[i] high = requester i wants the channel.
sel  output 2  mux select; sel[1] drives s1, sel[0] drives s0.
gnt  output 4  one-hot grant; all-zero when no tenure is active.
out_valid  output 1  high when the mux output reflects the granted input.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- All outputs are registered.
- Reset values:
  - state = IDLE, sel = 2'b00, gnt = 4'b0000, out_valid = 0.
  - Priority pointer ptr = 3, so requester 0 has highest priority after reset.
  - Settle counter and hold counter = 0.
- Arbitration function: the winner is the first index i with req[i] = 1, scanning (ptr+1), (ptr+2), (ptr+3), ptr, all mod 4 (2-bit wrap).
- States:
  - IDLE: gnt = 0, out_valid = 0. If req != 0 at an edge: sel <= winner, settle counter <= SETTLE_CYCLES-1, go to SETTLE. Otherwise stay in IDLE and hold sel.
  - SETTLE: gnt = 0, out_valid = 0.
    - If req[sel] = 0 at an edge (abort): go to IDLE. ptr is unchanged and sel is held.
    - Else if counter = 0: go to GRANT, gnt <= onehot(sel), out_valid <= 1, hold counter <= 1.
    - Else decrement the counter.
  - GRANT: a tenure ends at an edge where req[sel] = 0 OR hold counter = MAX_HOLD.
    - Not ending: hold counter increments; gnt, sel and out_valid are held.
    - Ending: gnt <= 0, out_valid <= 0, ptr <= sel. Then re-arbitrate in the same edge using the pre-update req and ptr = sel:
      - If req == 0: go to IDLE.
      - Else: sel <= winner, counter <= SETTLE_CYCLES-1, go to SETTLE. This applies even when the winner equals the old sel, which only happens when it is the sole requester after hitting MAX_HOLD.
- Latency:
  - req sampled at edge N in IDLE: sel valid after edge N; gnt and out_valid high after edge N+SETTLE_CYCLES.
  - Minimum gap between two tenures: SETTLE_CYCLES cycles with gnt = 0.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt != 0 exactly when out_valid = 1.
  - sel never changes while out_valid = 1.
- Requests from non-holders are ignored during SETTLE and GRANT; no preemption.
- Simultaneous release and new request on the same edge: resolved by the GRANT rule above, with no IDLE bubble.
- rst asserted mid-tenure: gnt and out_valid drop immediately (asynchronously) and every register returns to its reset value. After release, arbitration restarts with ptr = 3.
- Illegal parameter values are unsupported.
  - Counter widths: 4 bits for the settle counter, 8 bits for the hold counter.
  - Hold counter saturation: not required, because the counter never exceeds MAX_HOLD.

Test Plan:
- Reset/single request: rst high, check all outputs 0. Release rst, req = 4'b0100 at edge N → sel = 2 after N; gnt = 4'b0100 and out_valid = 1 after N+2. Drop req at edge M → gnt = 0, out_valid = 0 after M, state IDLE.
- Round-robin fairness: req = 4'b1111 held constant → grant order 0, 1, 2, 3, 0. Each tenure lasts 8 cycles, with a 2-cycle gap between tenures during which gnt = 0 and out_valid = 0.
- Wrap-around priority: after a tenure of requester 3 ends, req = 4'b0011 → requester 0 wins before 1. After a tenure of requester 1 ends, req = 4'b0011 → requester 0 wins.
- Sole requester at burst limit: req = 4'b0010 held → gnt high 8 cycles, low 2 cycles, high 8 again; sel stays 1 throughout.
- Abort in SETTLE: req = 4'b0001 for one cycle only → sel = 0, state reaches SETTLE, then IDLE. gnt never asserts and the next winner order is unchanged.
- Reset mid-tenure: assert rst asynchronously while gnt = 4'b1000 → gnt = 0 and out_valid = 0 before the next clk edge. After release with req = 4'b1001, requester 0 is granted first.
